// File: rtl/mc_accum.sv
// Monte-Carlo trial accumulator: sums 2^LOG2_TRIALS complex 256-sample frames per bin,
// then streams the per-bin mean (floor of sum / trials) as one frame and re-arms.
module mc_accum #(
  parameter int LOG2_TRIALS = 4,
  parameter int FRAME_LEN   = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] y_real,
  input  logic signed [15:0] y_img,
  output logic               out_valid,
  output logic signed [15:0] avg_real,
  output logic signed [15:0] avg_img,
  output logic [7:0]         out_idx,
  output logic               busy,
  output logic               drop_err
);

  localparam int         W          = 16 + LOG2_TRIALS;
  localparam int         TRIALS     = 1 << LOG2_TRIALS;
  localparam logic [7:0] LAST_IDX   = 8'(FRAME_LEN - 1);
  localparam logic [8:0] LAST_TRIAL = 9'(TRIALS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DUMP  = 1'b1
  } state_t;

  state_t              state_r;
  logic [7:0]          sample_cnt_r;
  logic [8:0]          trial_cnt_r;
  logic signed [W-1:0] acc_re_r [FRAME_LEN];
  logic signed [W-1:0] acc_im_r [FRAME_LEN];

  logic                accept_s;
  logic signed [W-1:0] rd_re_s;
  logic signed [W-1:0] rd_im_s;
  logic signed [W-1:0] ext_re_s;
  logic signed [W-1:0] ext_im_s;
  logic signed [W-1:0] sum_re_s;
  logic signed [W-1:0] sum_im_s;
  logic signed [15:0]  avg_re_s;
  logic signed [15:0]  avg_im_s;

  // Datapath: accept qualification, read-modify-write sums and the averaging shift.
  // sample_cnt_r addresses the arrays in both states, so the dump reuses the input counter.
  always_comb begin
    accept_s = 1'b0;
    sum_re_s = '0;
    sum_im_s = '0;
    if (in_valid && (state_r == ST_ACCUM)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    rd_re_s  = acc_re_r[sample_cnt_r];
    rd_im_s  = acc_im_r[sample_cnt_r];
    ext_re_s = W'(y_real);
    ext_im_s = W'(y_img);
    if (trial_cnt_r == 9'd0) begin
      sum_re_s = ext_re_s;
      sum_im_s = ext_im_s;
    end else begin
      sum_re_s = rd_re_s + ext_re_s;
      sum_im_s = rd_im_s + ext_im_s;
    end
    avg_re_s = 16'(rd_re_s >>> LOG2_TRIALS);
    avg_im_s = 16'(rd_im_s >>> LOG2_TRIALS);
  end

  // Accumulator write port; no reset needed because trial 0 overwrites stale sums.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      acc_re_r[sample_cnt_r] <= sum_re_s;
      acc_im_r[sample_cnt_r] <= sum_im_s;
    end
  end

  // Control FSM with counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_ACCUM;
      sample_cnt_r <= 8'd0;
      trial_cnt_r  <= 9'd0;
      out_valid    <= 1'b0;
      avg_real     <= 16'sd0;
      avg_img      <= 16'sd0;
      out_idx      <= 8'd0;
      busy         <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          out_valid <= 1'b0;
          avg_real  <= 16'sd0;
          avg_img   <= 16'sd0;
          out_idx   <= 8'd0;
          busy      <= 1'b0;
          if (accept_s) begin
            if (sample_cnt_r == LAST_IDX) begin
              sample_cnt_r <= 8'd0;
              if (trial_cnt_r == LAST_TRIAL) begin
                trial_cnt_r <= 9'd0;
                state_r     <= ST_DUMP;
                busy        <= 1'b1;
              end else begin
                trial_cnt_r <= trial_cnt_r + 9'd1;
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + 8'd1;
            end
          end
        end
        ST_DUMP: begin
          out_valid <= 1'b1;
          avg_real  <= avg_re_s;
          avg_img   <= avg_im_s;
          out_idx   <= sample_cnt_r;
          if (in_valid) begin
            drop_err <= 1'b1;
          end
          if (sample_cnt_r == LAST_IDX) begin
            sample_cnt_r <= 8'd0;
            state_r      <= ST_ACCUM;
            busy         <= 1'b0;
          end else begin
            sample_cnt_r <= sample_cnt_r + 8'd1;
            busy         <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_ACCUM;
          sample_cnt_r <= 8'd0;
          trial_cnt_r  <= 9'd0;
          out_valid    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
